// File: rtl/shake_load_buffer.sv
// SHAKE load stage: header/message word intake, in-line SHAKE padding and a ping-pong
// pair of rate-sized block buffers handed to the permutation over valid/ready.
module shake_load_buffer #(
    parameter int unsigned W         = 64,
    parameter int unsigned MAX_RATE  = 1344,
    parameter int unsigned HDR_WORDS = 64 / W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [W-1:0]        data_in,
    output logic [MAX_RATE-1:0] block_o,
    output logic                block_valid_o,
    input  logic                block_ready_i,
    output logic                block_last_o,
    output logic [31:0]         output_size,
    output logic [1:0]          operation_mode
);

    localparam int unsigned WB    = W / 8;
    localparam int unsigned RW128 = MAX_RATE / W;
    localparam int unsigned RW256 = 1088 / W;
    localparam int unsigned IW    = $clog2(RW128);

    typedef enum logic [1:0] {StHeader, StAbsorb, StPad, StDrain} state_e;

    state_e              state_q;
    logic                started_q;
    logic [MAX_RATE-1:0] bufs_q [2];
    logic [1:0]          full_q;
    logic [1:0]          last_q;
    logic                wptr_q;
    logic                rptr_q;
    logic [IW-1:0]       widx_q;
    logic [1:0]          hdr_cnt_q;
    logic [63:0]         hdr_q;
    logic [29:0]         bytes_left_q;
    logic                rate_sel_q;
    logic                pad_placed_q;

    logic [63:0]   hdr_full;
    logic [IW-1:0] rw_last;
    logic          at_last_idx;
    logic          final_word;
    logic          partial;
    logic          fire;
    logic          consume;
    logic [W-1:0]  abs_word;
    logic [W-1:0]  pad_word;

    assign block_o       = bufs_q[rptr_q];
    assign block_valid_o = full_q[rptr_q];
    assign block_last_o  = last_q[rptr_q];

    // started_q holds ready_o low until the first edge after reset release
    assign ready_o = started_q && (state_q == StHeader || state_q == StAbsorb) && !full_q[wptr_q];

    assign fire        = valid_i && ready_o;
    assign consume     = block_valid_o && block_ready_i;
    assign rw_last     = rate_sel_q ? IW'(RW256 - 1) : IW'(RW128 - 1);
    assign at_last_idx = (widx_q == rw_last);
    assign final_word  = (bytes_left_q <= 30'(WB));
    assign partial     = (bytes_left_q < 30'(WB));

    always_comb begin
        hdr_full = hdr_q;
        hdr_full[int'(hdr_cnt_q) * W +: W] = data_in;
    end

    // Message word with tail bytes masked and the 0x1F/0x80 pad bytes merged in
    always_comb begin
        abs_word = '0;
        for (int unsigned b = 0; b < WB; b++) begin
            if (!final_word || 30'(b) < bytes_left_q) begin
                abs_word[b*8 +: 8] = data_in[b*8 +: 8];
            end else if (30'(b) == bytes_left_q) begin
                abs_word[b*8 +: 8] = 8'h1F;
            end
        end
        if (final_word && partial && at_last_idx) begin
            abs_word[W-1 -: 8] = abs_word[W-1 -: 8] | 8'h80;
        end
    end

    always_comb begin
        pad_word = '0;
        if (!pad_placed_q) begin
            pad_word[7:0] = 8'h1F;
        end
        if (at_last_idx) begin
            pad_word[W-1 -: 8] = pad_word[W-1 -: 8] | 8'h80;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StHeader;
            started_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                bufs_q[i] <= '0;
            end
            full_q         <= '0;
            last_q         <= '0;
            wptr_q         <= 1'b0;
            rptr_q         <= 1'b0;
            widx_q         <= '0;
            hdr_cnt_q      <= '0;
            hdr_q          <= '0;
            bytes_left_q   <= '0;
            rate_sel_q     <= 1'b0;
            pad_placed_q   <= 1'b0;
            output_size    <= '0;
            operation_mode <= '0;
        end else begin
            started_q <= 1'b1;

            if (consume) begin
                full_q[rptr_q] <= 1'b0;
                last_q[rptr_q] <= 1'b0;
                bufs_q[rptr_q] <= '0;
                rptr_q         <= ~rptr_q;
            end

            unique case (state_q)
                StHeader: begin
                    if (fire) begin
                        if (hdr_cnt_q == 2'(HDR_WORDS - 1)) begin
                            hdr_cnt_q      <= '0;
                            hdr_q          <= '0;
                            output_size    <= hdr_full[31:0];
                            operation_mode <= hdr_full[33:32];
                            rate_sel_q     <= hdr_full[32];
                            bytes_left_q   <= hdr_full[63:34];
                            widx_q         <= '0;
                            pad_placed_q   <= 1'b0;
                            state_q        <= (hdr_full[63:34] != '0) ? StAbsorb : StPad;
                        end else begin
                            hdr_q     <= hdr_full;
                            hdr_cnt_q <= hdr_cnt_q + 2'd1;
                        end
                    end
                end

                StAbsorb: begin
                    if (fire) begin
                        bufs_q[wptr_q][int'(widx_q) * W +: W] <= abs_word;
                        bytes_left_q <= bytes_left_q - 30'(WB);
                        if (at_last_idx) begin
                            full_q[wptr_q] <= 1'b1;
                            last_q[wptr_q] <= final_word && partial;
                            wptr_q         <= ~wptr_q;
                            widx_q         <= '0;
                        end else begin
                            widx_q <= widx_q + IW'(1);
                        end
                        if (final_word) begin
                            pad_placed_q <= partial;
                            // A short final word in the block's last slot already carries 0x80
                            state_q      <= (partial && at_last_idx) ? StDrain : StPad;
                        end
                    end
                end

                StPad: begin
                    if (!full_q[wptr_q]) begin
                        bufs_q[wptr_q][int'(widx_q) * W +: W] <= pad_word;
                        pad_placed_q <= 1'b1;
                        if (at_last_idx) begin
                            full_q[wptr_q] <= 1'b1;
                            last_q[wptr_q] <= 1'b1;
                            wptr_q         <= ~wptr_q;
                            widx_q         <= '0;
                            state_q        <= StDrain;
                        end else begin
                            widx_q <= widx_q + IW'(1);
                        end
                    end
                end

                StDrain: begin
                    if (consume && block_last_o) begin
                        state_q <= StHeader;
                    end
                end

                default: state_q <= StHeader;
            endcase
        end
    end

endmodule

// File: tb/tb_shake_load_buffer.sv
// Bench for shake_load_buffer: drives headers and messages, checks every emitted block
// against a byte-level SHAKE padding model.
module tb_shake_load_buffer;

    localparam int unsigned W         = 64;
    localparam int unsigned MAX_RATE  = 1344;
    localparam int unsigned HDR_WORDS = 64 / W;
    localparam int unsigned WB        = W / 8;

    logic                clk;
    logic                rst;
    logic                valid_i;
    logic                ready_o;
    logic [W-1:0]        data_in;
    logic [MAX_RATE-1:0] block_o;
    logic                block_valid_o;
    logic                block_ready_i;
    logic                block_last_o;
    logic [31:0]         output_size;
    logic [1:0]          operation_mode;

    shake_load_buffer #(
        .W        (W),
        .MAX_RATE (MAX_RATE),
        .HDR_WORDS(HDR_WORDS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .data_in       (data_in),
        .block_o       (block_o),
        .block_valid_o (block_valid_o),
        .block_ready_i (block_ready_i),
        .block_last_o  (block_last_o),
        .output_size   (output_size),
        .operation_mode(operation_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]          msg [4096];
    logic [MAX_RATE-1:0] last_block;
    int                  words_at_hold;
    logic                ready_at_hold;
    bit                  coinc_seen;

    // Sends one header+message, consumes blocks and compares each with the padding model.
    // coincide: consumer only pulses ready when the source is stalled/finished, or exactly
    // when a block-completing word is being accepted.
    task automatic run_msg(input int len, input logic [1:0] mode, input logic [31:0] osize,
                           input int pct, input int hold, input bit coincide,
                           input bit garbage, input int exp_lat, input string name);
        int R, RW, nmw, nwords, nblk, plen, sent, got, last_xfer, first_valid, m, bad;
        logic [7:0] pad [4096];
        logic [63:0] hdr;
        logic [W-1:0] word;
        logic [MAX_RATE-1:0] exp_blk;
        logic exp_last;
        bit xfer, cons, done, completing;

        R      = mode[0] ? 136 : 168;
        RW     = R * 8 / W;
        nmw    = (len + WB - 1) / WB;
        nwords = HDR_WORDS + nmw;
        nblk   = len / R + 1;
        plen   = nblk * R;
        for (int i = len; i < nmw * WB; i++) msg[i] = garbage ? 8'($urandom) : 8'h00;
        for (int i = 0; i < plen; i++) pad[i] = (i < len) ? msg[i] : 8'h00;
        pad[len]      = pad[len] | 8'h1F;
        pad[plen - 1] = pad[plen - 1] | 8'h80;
        hdr = {len[29:0], mode, osize};

        sent = 0; got = 0; done = 0; last_xfer = -1; first_valid = -1;
        coinc_seen = 0;
        for (int budget = 0; budget < 4000 && !done; budget++) begin
            @(negedge clk);
            cyc++;
            if (first_valid < 0 && block_valid_o) first_valid = cyc;
            if (sent < nwords) begin
                if (sent < HDR_WORDS) begin
                    word = hdr[sent*W +: W];
                end else begin
                    m = sent - HDR_WORDS;
                    for (int b = 0; b < WB; b++) word[b*8 +: 8] = msg[m*WB + b];
                end
                valid_i = 1'b1;
                data_in = word;
                xfer    = ready_o;
            end else begin
                valid_i = 1'b0;
                data_in = W'({$urandom, $urandom});
                xfer    = 1'b0;
            end
            completing = xfer && (sent >= HDR_WORDS) && (((sent - HDR_WORDS) % RW) == RW - 1);
            if (budget == hold) begin
                words_at_hold = sent;
                ready_at_hold = ready_o;
            end
            if (budget < hold) cons = 1'b0;
            else if (coincide) cons = (completing && block_valid_o) || sent == nwords || !ready_o;
            else cons = ($urandom_range(99) < pct);
            block_ready_i = cons;
            if (cons && block_valid_o) begin
                if (completing) coinc_seen = 1;
                exp_blk = '0;
                for (int i = 0; i < R; i++) exp_blk[i*8 +: 8] = pad[got*R + i];
                exp_last = (got == nblk - 1);
                checks++;
                if (block_o !== exp_blk) begin
                    errors++;
                    bad = 0;
                    for (int k = MAX_RATE / 64 - 1; k >= 0; k--)
                        if (block_o[k*64 +: 64] !== exp_blk[k*64 +: 64]) bad = k;
                    $display("FAIL %s block%0d data: word%0d got %h exp %h", name, got, bad,
                             block_o[bad*64 +: 64], exp_blk[bad*64 +: 64]);
                end
                checks++;
                if (block_last_o !== exp_last) begin
                    errors++;
                    $display("FAIL %s block%0d last: got %b exp %b", name, got, block_last_o,
                             exp_last);
                end
                checks++;
                if (output_size !== osize || operation_mode !== mode) begin
                    errors++;
                    $display("FAIL %s hdr latch: got %h/%b exp %h/%b", name, output_size,
                             operation_mode, osize, mode);
                end
                last_block = block_o;
                got++;
                if (got == nblk) done = 1;
            end
            if (xfer) begin
                if (sent == nwords - 1) last_xfer = cyc;
                sent++;
            end
        end

        @(negedge clk);
        cyc++;
        valid_i       = 1'b0;
        block_ready_i = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: got %0d blocks exp %0d, sent %0d of %0d words", name,
                     got, nblk, sent, nwords);
        end else if (ready_o !== 1'b1 || block_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL %s return to header: ready %b valid %b exp 1 0", name, ready_o,
                     block_valid_o);
        end
        if (exp_lat >= 0) begin
            checks++;
            if (first_valid - last_xfer != exp_lat) begin
                errors++;
                $display("FAIL %s latency: got %0d exp %0d", name, first_valid - last_xfer,
                         exp_lat);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; valid_i = 1'b0; block_ready_i = 1'b0; data_in = '0;
        #13;
        checks++;
        if ({ready_o, block_valid_o, block_last_o, output_size, operation_mode} !== '0 ||
            block_o !== '0) begin
            errors++;
            $display("FAIL reset outputs: got rdy %b v %b l %b os %h om %b exp all 0", ready_o,
                     block_valid_o, block_last_o, output_size, operation_mode);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL ready before first edge: got %b exp 0", ready_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready after first edge: got %b exp 1", ready_o);
        end
    endtask

    task automatic test_empty_msg();
        run_msg(0, 2'b00, 32'd256, 100, 0, 0, 0, 22, "empty");
        checks++;
        if (last_block[7:0] !== 8'h1F || last_block[167*8 +: 8] !== 8'h80) begin
            errors++;
            $display("FAIL empty pad bytes: got %h/%h exp 1f/80", last_block[7:0],
                     last_block[167*8 +: 8]);
        end
    endtask

    task automatic test_short_256();
        msg[0] = 8'hAA; msg[1] = 8'hBB; msg[2] = 8'hCC;
        run_msg(3, 2'b01, 32'd512, 100, 0, 0, 0, 17, "short256");
        checks++;
        if (last_block[31:0] !== 32'h1FCCBBAA || last_block[135*8 +: 8] !== 8'h80 ||
            last_block[1343:1088] !== '0) begin
            errors++;
            $display("FAIL short256 bytes: got %h/%h hi %0d exp 1fccbbaa/80 hi 0",
                     last_block[31:0], last_block[135*8 +: 8], last_block[1343:1088] != '0);
        end
    endtask

    task automatic test_exact_block();
        for (int i = 0; i < 168; i++) msg[i] = 8'($urandom);
        run_msg(168, 2'b00, 32'd128, 100, 0, 0, 1, 1, "exact");
    endtask

    task automatic test_len167();
        for (int i = 0; i < 167; i++) msg[i] = 8'($urandom);
        run_msg(167, 2'b00, 32'd64, 100, 0, 0, 1, 1, "len167");
        checks++;
        if (last_block[167*8 +: 8] !== 8'h9F) begin
            errors++;
            $display("FAIL len167 byte167: got %h exp 9f", last_block[167*8 +: 8]);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 500; i++) msg[i] = 8'($urandom);
        run_msg(500, 2'b00, 32'd1024, 0, 60, 1, 1, -1, "backpressure");
        checks++;
        if (words_at_hold != int'(HDR_WORDS) + 42 || ready_at_hold !== 1'b0) begin
            errors++;
            $display("FAIL stall: got %0d words rdy %b exp %0d words rdy 0", words_at_hold,
                     ready_at_hold, HDR_WORDS + 42);
        end
        checks++;
        if (!coinc_seen) begin
            errors++;
            $display("FAIL coincident fill/consume: got 0 exp 1");
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] hdr;
        hdr = {30'd500, 2'b11, 32'hDEADBEEF};
        @(negedge clk);
        valid_i = 1'b1;
        data_in = hdr;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            data_in = W'({$urandom, $urandom});
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({ready_o, block_valid_o, block_last_o, output_size, operation_mode} !== '0 ||
            block_o !== '0) begin
            errors++;
            $display("FAIL mid reset outputs: got rdy %b v %b l %b os %h om %b exp all 0",
                     ready_o, block_valid_o, block_last_o, output_size, operation_mode);
        end
        valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_msg(0, 2'b00, 32'd256, 100, 0, 0, 0, 22, "after_reset");
    endtask

    task automatic test_random();
        int len;
        logic [1:0] mode;
        for (int t = 0; t < 8; t++) begin
            len  = int'($urandom_range(400));
            mode = 2'($urandom);
            for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
            run_msg(len, mode, $urandom, int'($urandom_range(100, 20)), 0, 0, 1, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_empty_msg();
        test_short_256();
        test_exact_block();
        test_len167();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shake_load_buffer.md
Name: shake_load_buffer

Overview:
- Parametrised successor to the single-buffer SHAKE load stage.
- Accepts a header and then a message stream of W-bit words, and applies SHAKE padding (0x1F…0x80) in hardware.
- Assembles rate-sized blocks into a ping-pong pair of block buffers.
- Presents blocks to the permutation stage over a valid/ready handshake; the rate is selected per message (SHAKE128 or SHAKE256).

Parameters:
- W, 64, input word width in bits. Legal values: 32 or 64 (must divide both 1344 and 1088).
- MAX_RATE, 1344, block width in bits (the SHAKE128 rate). The SHAKE256 rate is fixed at 1088.
- HDR_WORDS, 64/W, derived. Number of words in the header.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  source word valid.
- ready_o  out  1  block can accept a word; a transfer occurs when valid_i & ready_o.
- data_in  in  W  header or message word, little-endian bytes.
- block_o  out  MAX_RATE  head buffer contents. Byte 0 is bits [7:0]; word k occupies bits [(k+1)W-1:kW].
- block_valid_o  out  1  head buffer holds a complete block.
- block_ready_i  in  1  consumer accepts the block; frees the head buffer.
- block_last_o  out  1  head block is the message's final padded block.
- output_size  out  32  latched requested output length, in bits.
- operation_mode  out  2  latched mode; bit 0: 0 = SHAKE128 (rate 1344), 1 = SHAKE256 (rate 1088).

Behaviour:
- Reset (rst=0, asynchronous): every output is 0, both buffers are empty and cleared, read/write pointers are 0, state is HEADER.
  - ready_o rises on the first clock edge after rst deasserts.
  - Reset mid-operation discards all buffered data.
- 64-bit header, assembled from HDR_WORDS words, low word first:
  - [31:0] output_size
  - [33:32] mode
  - [63:34] msg_len in bytes
- Mode handling: operation_mode latches mode verbatim. Only mode bit 0 selects the rate; mode bit 1 is passed through unused.
- Derived block size: RW = rate/W words per block (21 or 17 at W=64). Bits [MAX_RATE-1:rate] of block_o are 0 in SHAKE256.
- output_size and operation_mode update on the edge that accepts the final header word, and hold until the next header.
- States:
  - HEADER: accept HDR_WORDS words. Next state is ABSORB if msg_len>0, otherwise PAD.
  - ABSORB: each accepted word is written to the fill buffer at word index widx; widx increments and wraps to 0 at RW.
    - The block is marked full on the edge that writes its final word, and the fill pointer toggles.
    - bytes_left decrements by W/8 per word.
    - Final message word (bytes_left ≤ W/8): bytes ≥ bytes_left are zeroed. If bytes_left < W/8, byte bytes_left = 0x1F. Next state is PAD.
  - PAD: ready_o=0; one word is generated per cycle.
    - If 0x1F is not yet placed (message ended on a word boundary), the first generated word carries it in byte 0.
    - Zero words fill the remaining indices; the last byte of the block is ORed with 0x80 (0x9F if it coincides with 0x1F).
    - If the message exactly filled a block, a whole extra block is generated: 0x1F at byte 0, 0x80 at byte rate/8-1.
    - The final padded block is marked last. Next state is DRAIN.
  - DRAIN: ready_o=0 until the last block is consumed (block_valid_o & block_ready_i & block_last_o); then HEADER.
- ready_o = (state is HEADER or ABSORB) and the fill buffer is not full.
  - With both buffers full, ready_o=0; no word is ever dropped.
- Block hand-off:
  - block_valid_o and block_last_o reflect the head buffer's registered flags. They assert the cycle after the edge that marks the block full.
  - On block_valid_o & block_ready_i, the head buffer is cleared to empty and the read pointer toggles.
  - A simultaneous fill-complete into one buffer and consume of the other is legal, and both take effect.
  - PAD stalls while its target buffer is still full.
- Latency:
  - Unpadded block: final word accepted at edge t → block_valid_o=1 at cycle t+1.
  - Padded block with k generated words: block_valid_o=1 at cycle t+1+k.

Test Plan (W=64):
1. Header {len=0, mode=00, output_size=256} → 21 PAD cycles; one block with byte0=0x1F, byte167=0x80, all other bytes 0; block_last_o=1; output_size=256, operation_mode=00.
2. Header {len=3, mode=01}, word 0x00000000_00CCBBAA → bytes 0..3 = AA BB CC 1F, byte135=0x80; bits [1343:1088]=0; block_last_o=1.
3. len=168, mode=00, 21 full words → block0 is the data unchanged with last=0; block1 has 0x1F at byte 0 and 0x80 at byte 167, last=1.
4. len=167, mode=00 → byte 167 of the single block = 0x9F; block_last_o=1.
5. len=500, mode=00, block_ready_i held 0 → ready_o falls after 2 blocks fill. Release one cycle at a time: blocks are emitted in order, 3 blocks total, the last with last=1, and no data is lost. Include one cycle where consume and fill coincide.
6. Pull rst low mid-ABSORB → all outputs 0 immediately. After release, a fresh header {len=0} produces the block from test 1.
